// File: rtl/mul_shift_add_if.sv
// Handshake and operand bundle for mul_shift_add. The ovf signal exists only
// when MUL_OVF_EN is defined.
interface mul_shift_add_if #(
  parameter int AW = 32,
  parameter int BW = 16,
  parameter int CW = 4
);
  logic [AW-1:0]    a;
  logic [BW-1:0]    b;
  logic [BW-1:0]    r;
  logic             start;
  logic [AW+BW-1:0] p;
  logic             busy;
  logic             ready;
  logic [CW-1:0]    count;
`ifdef MUL_OVF_EN
  logic             ovf;

  modport master (output a, b, r, start, input p, busy, ready, count, ovf);
  modport slave  (input a, b, r, start, output p, busy, ready, count, ovf);
`else
  modport master (output a, b, r, start, input p, busy, ready, count);
  modport slave  (input a, b, r, start, output p, busy, ready, count);
`endif
endinterface

// File: rtl/mul_shift_add.sv
// Sequential radix-2 shift-add multiply-accumulate: p = a*b + r, one multiplier
// bit per cycle. Optional MUL_OVF_EN adds ovf (result exceeds AW bits).
module mul_shift_add #(
  parameter int AW = 32,
  parameter int BW = 16,
  parameter int CW = 4
) (
  input  logic              clk,
  input  logic              clrn,
  mul_shift_add_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [AW+BW-1:0] reg_m;
  logic [BW-1:0]    reg_b;
  logic [AW+BW-1:0] reg_p;
  logic [CW-1:0]    count;
  logic [AW+BW-1:0] p_step;
  logic             last;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // start has priority and restarts a running operation
  always_comb begin
    state_nxt = state;
    last      = (count == CW'(BW - 1));
    p_step    = reg_b[0] ? (reg_p + reg_m) : reg_p;
    if (bus.start)
      state_nxt = S_BUSY;
    else if (state == S_BUSY && last)
      state_nxt = S_DONE;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      reg_m <= '0;
      reg_b <= '0;
      reg_p <= '0;
      count <= '0;
    end else if (bus.start) begin
      reg_m <= {{BW{1'b0}}, bus.a};
      reg_b <= bus.b;
      reg_p <= {{AW{1'b0}}, bus.r};
      count <= '0;
    end else if (state == S_BUSY) begin
      reg_p <= p_step;
      reg_m <= reg_m << 1;
      reg_b <= reg_b >> 1;
      count <= count + 1'b1;
    end
  end

`ifdef MUL_OVF_EN
  logic ovf;

  // judged on the value being written on the completion edge
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      ovf <= 1'b0;
    else if (bus.start)
      ovf <= 1'b0;
    else if (state == S_BUSY && last)
      ovf <= (p_step[AW+BW-1:AW] != '0);
  end

  assign bus.ovf = ovf;
`endif

  assign bus.p     = reg_p;
  assign bus.busy  = (state == S_BUSY);
  assign bus.ready = (state == S_DONE);
  assign bus.count = count;

endmodule

// File: tb/tb_mul_shift_add.sv
// Randomised and directed bench for mul_shift_add against an arithmetic
// reference (a*b + r). Define MUL_OVF_EN to also check ovf.
module tb_mul_shift_add;

  localparam int AW = 32;
  localparam int BW = 16;
  localparam int CW = 4;

  logic clk;
  logic clrn;
  int   checks;
  int   errors;

  mul_shift_add_if #(.AW(AW), .BW(BW), .CW(CW)) bus ();

  mul_shift_add #(.AW(AW), .BW(BW), .CW(CW)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] ai, input logic [15:0] bi,
                                        input logic [15:0] ri);
    longint unsigned prod;
    prod = longint'(ai) * longint'(bi) + longint'(ri);
    return prod;
  endfunction

  task automatic launch(input logic [31:0] ai, input logic [15:0] bi, input logic [15:0] ri);
    @(negedge clk);
    bus.a = ai; bus.b = bi; bus.r = ri; bus.start = 1'b1;
    @(posedge clk); #1;
    check("start_busy", bus.busy, 1);
    check("start_ready", bus.ready, 0);
    check("start_count", bus.count, 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = 16'($urandom); bus.r = 16'($urandom);
  endtask

  task automatic run_op(input logic [31:0] ai, input logic [15:0] bi, input logic [15:0] ri);
    logic [63:0] exp;
    exp = model(ai, bi, ri);
    launch(ai, bi, ri);
    for (int i = 1; i <= BW; i++) begin
      @(posedge clk); #1;
      if (i < BW) begin
        check("lat_ready", bus.ready, 0);
        check("lat_count", bus.count, 64'(i));
      end
    end
    check("done_ready", bus.ready, 1);
    check("done_busy", bus.busy, 0);
    check("done_count", bus.count, 0);
    check("done_p", bus.p, exp);
`ifdef MUL_OVF_EN
    check("done_ovf", bus.ovf, 64'(exp[47:32] != 16'h0));
`endif
    repeat (3) @(posedge clk);
    #1;
    check("hold_p", bus.p, exp);
    check("hold_ready", bus.ready, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clrn = 1'b0;
    bus.a = '0; bus.b = '0; bus.r = '0; bus.start = 1'b0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_count", bus.count, 0);
    check("rst_p", bus.p, 0);
`ifdef MUL_OVF_EN
    check("rst_ovf", bus.ovf, 0);
`endif
    @(negedge clk);
    clrn = 1'b1;

    run_op(32'd100, 16'd7, 16'd3);
    run_op(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF);
    run_op(32'hDEAD_BEEF, 16'h0000, 16'h1234);
    run_op(32'h1234_5678, 16'h00FF, 16'h0042);
    check("tp_703", model(32'd100, 16'd7, 16'd3), 64'h2BF);

    // restart at busy cycle 8
    launch(32'd5, 16'd5, 16'd0);
    repeat (7) begin
      @(posedge clk); #1;
      check("rs_ready", bus.ready, 0);
    end
    run_op(32'd3, 16'd4, 16'd1);

    // asynchronous reset mid-operation
    launch(32'hCAFE_F00D, 16'hBEEF, 16'h55AA);
    repeat (5) @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_ready", bus.ready, 0);
    check("arst_p", bus.p, 0);
    check("arst_count", bus.count, 0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_busy", bus.busy, 0);
    check("idle_ready", bus.ready, 0);
    check("idle_p", bus.p, 0);

    for (int n = 0; n < 20; n++)
      run_op($urandom, 16'($urandom), 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_shift_add.md
Name: mul_shift_add

Overview:
- Sequential radix-2 shift-add multiply-accumulate unit: p = a*b + r, unsigned.
- Inverse datapath of the team's 32/16 restoring divider. Feeding it the divider's quotient, divisor and remainder reconstructs the original dividend.
- Used for divide-result checking and as the general 32x16 multiplier of the arithmetic unit.
- Same start/busy/ready/count handshake as the divider: one bit of b is consumed per cycle.

Parameters:
- AW, 32, multiplicand width (a).
- BW, 16, multiplier and addend width (b, r); iteration count = BW.
- CW, 4, counter width; must equal clog2(BW).

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  asynchronous active-low reset
- a  input  AW  multiplicand (e.g. divider quotient); sampled only on start
- b  input  BW  multiplier (e.g. divider divisor); sampled only on start
- r  input  BW  addend (e.g. divider remainder); sampled only on start
- start  input  1  begin operation; one-cycle pulse, level also accepted
- p  output  AW+BW  result a*b + r; valid when ready=1
- busy  output  1  operation in progress
- ready  output  1  result valid; held until next start or reset
- count  output  CW  iteration counter
- ovf  output  1  only when MUL_OVF_EN is defined (see Optional Feature)

Behaviour:
- Reset (clrn=0, asynchronous): busy=0, ready=0, count=0, p=0; internal multiplicand and multiplier registers cleared. Applies mid-operation too: the operation is abandoned and the block stays idle until start.
- Internal registers:
  - reg_m, AW+BW bits: shifted multiplicand.
  - reg_b, BW bits: multiplier, shifted right.
  - reg_p, AW+BW bits: accumulator, drives p.
- start=1 on a clock edge (highest priority, also while busy, which restarts):
  - reg_m <= {BW'b0, a}; reg_b <= b; reg_p <= {AW'b0, r}
  - count <= 0; busy <= 1; ready <= 0
- Each edge with busy=1 and start=0:
  - if reg_b[0] then reg_p <= reg_p + reg_m (AW+BW-bit add, no carry-out possible)
  - reg_m <= reg_m << 1; reg_b <= reg_b >> 1; count <= count + 1
  - if count == BW-1: busy <= 0, ready <= 1 on the same edge.
- Latency: start edge, then exactly BW (16) busy edges; ready=1 and p final after the 16th.
- Range: max result (2^32-1)(2^16-1)+(2^16-1) = 0xFFFF_0000_0000 < 2^48, so the full-width p never wraps.
- Idle (busy=0, start=0): all registers hold; p and ready stable.
- count: wraps 15->0 only coincident with completion; holds its value when idle.
- No early termination when reg_b becomes 0; latency is fixed at BW cycles.
- Inputs a, b, r may change freely after the start edge.

Optional Feature:
- Macro MUL_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), reset 0, cleared on start.
  - Set on the completion edge when the final p[AW+BW-1:AW] != 0, i.e. the result does not fit a 32-bit divider dividend.
  - Holds with ready.
- Undefined: port and logic absent; p behaviour identical.

Test Plan:
- a=100, b=7, r=3, start pulse -> busy for 16 cycles; then ready=1, p=0x0000_0000_02BF (703), count=0; ovf=0 if enabled.
- a=0xFFFF_FFFF, b=0xFFFF, r=0xFFFF -> p=0xFFFF_0000_0000 after 16 cycles, no wrap; ovf=1 if enabled.
- a=0xDEAD_BEEF, b=0, r=0x1234 -> p=0x1234 after full 16-cycle latency (no early done).
- a=5, b=5, r=0; second start at busy cycle 8 with a=3, b=4, r=1 -> ready stays 0 until 16 cycles after the second start; p=13.
- clrn low at busy cycle 5 -> busy=0, ready=0, p=0 immediately (asynchronously, no clock needed); remains idle with start=0.
- a=0x1234_5678, b=0x00FF, r=0x0042 -> p=0x0012_2222_21CA; ovf=1 if enabled. Round-trip check: dividing p[31:0] by b through the divider reproduces the divider's bit-consistent quotient/remainder.
